// File: rtl/sobel_window_ctrl.sv
// Sobel frame sequencer: counts accepted pixels, drives line-buffer enables, tags 3x3 windows (1-cycle latency).
// Back-pressure: pixels are taken only when src_nempty & dst_ready in RUN; stalls hold all counters.
module sobel_window_ctrl #(
    parameter int LB_DEPTH = 2048,
    parameter int DIM_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic             src_nempty,
    output logic             src_re,
    input  logic             dst_ready,
    output logic             lb_we0,
    output logic             lb_re0,
    output logic             lb_re1,
    output logic             lb_clr,
    output logic             win_valid,
    output logic [DIM_W-1:0] win_col,
    output logic [DIM_W-1:0] win_row,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DIM_W:0] LB_MAX = (DIM_W+1)'(LB_DEPTH);

    state_t           state_q, state_d;
    logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
    logic [DIM_W-1:0] win_col_q, win_col_d, win_row_q, win_row_d;
    logic             win_vld_q, win_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             clr_q, clr_d;
    logic             err_q, err_d;

    logic accept;
    logic row_ge1, row_ge2, col_ge2;
    logic col_last, row_last;
    logic geom_ok;

    // abort outranks a simultaneous accept so the aborted pixel stays in the source FIFO
    assign accept   = (state_q == S_RUN) & src_nempty & dst_ready & ~abort;
    assign row_ge1  = (row_q != '0);
    assign row_ge2  = (row_q >= DIM_W'(2));
    assign col_ge2  = (col_q >= DIM_W'(2));
    assign col_last = (col_q == w_q - DIM_W'(1));
    assign row_last = (row_q == h_q - DIM_W'(1));
    assign geom_ok  = (img_width >= DIM_W'(3)) && ({1'b0, img_width} <= LB_MAX)
                    && (img_height >= DIM_W'(3));

    assign src_re = accept;
    assign lb_we0 = accept;
    assign lb_re0 = accept & row_ge1;
    assign lb_re1 = accept & row_ge2;

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        h_d       = h_q;
        col_d     = col_q;
        row_d     = row_q;
        win_vld_d = accept & row_ge2 & col_ge2;
        win_col_d = win_col_q;
        win_row_d = win_row_q;
        done_d    = 1'b0;
        clr_d     = 1'b0;
        err_d     = 1'b0;

        if (win_vld_d) begin
            win_col_d = col_q - DIM_W'(1);
            win_row_d = row_q - DIM_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (abort) begin
                    clr_d = 1'b1;
                end else if (start) begin
                    if (geom_ok) begin
                        w_d     = img_width;
                        h_d     = img_height;
                        col_d   = '0;
                        row_d   = '0;
                        clr_d   = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    col_d   = '0;
                    row_d   = '0;
                    clr_d   = 1'b1;
                end else if (accept) begin
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + DIM_W'(1);
                        end
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (abort) begin
                    col_d = '0;
                    row_d = '0;
                    clr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            w_q       <= '0;
            h_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            win_vld_q <= 1'b0;
            win_col_q <= '0;
            win_row_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clr_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            h_q       <= h_d;
            col_q     <= col_d;
            row_q     <= row_d;
            win_vld_q <= win_vld_d;
            win_col_q <= win_col_d;
            win_row_q <= win_row_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            clr_q     <= clr_d;
            err_q     <= err_d;
        end
    end

    assign lb_clr     = clr_q;
    assign win_valid  = win_vld_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl: pixel-count reference model checked every cycle, plus literal frame expectations.
module tb_sobel_window_ctrl;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, src_nempty, dst_ready;
    logic [DW-1:0] img_width, img_height;
    logic          src_re, lb_we0, lb_re0, lb_re1, lb_clr;
    logic          win_valid, busy, frame_done, cfg_err;
    logic [DW-1:0] win_col, win_row;

    sobel_window_ctrl #(.LB_DEPTH(2048), .DIM_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .img_width(img_width), .img_height(img_height),
        .src_nempty(src_nempty), .src_re(src_re), .dst_ready(dst_ready),
        .lb_we0(lb_we0), .lb_re0(lb_re0), .lb_re1(lb_re1), .lb_clr(lb_clr),
        .win_valid(win_valid), .win_col(win_col), .win_row(win_row),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is just a count of accepted pixels; row/col follow by division.
    int mst, mw, mh, mn;
    int e_vld, e_col, e_row, e_busy, e_done, e_clr, e_err;

    int cyc = 0, last_acc = 0, done_at = 0;
    int n_re = 0, n_we0 = 0, n_re0 = 0, n_re1 = 0, n_clr = 0, n_done = 0, n_err = 0, n_vld = 0;
    int n_re_nrdy = 0;
    int wins[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mst = 0; mw = 0; mh = 0; mn = 0;
        e_vld = 0; e_col = 0; e_row = 0; e_busy = 0; e_done = 0; e_clr = 0; e_err = 0;
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the next rising edge.
    task automatic tick();
        int acc, r, c;
        @(negedge clk);
        cyc++;
        if (!rst_n) model_reset();
        acc = (mst == 1 && src_nempty && dst_ready && !abort) ? 1 : 0;
        r = (mst == 1) ? mn / mw : 0;
        c = (mst == 1) ? mn % mw : 0;

        chk("src_re", 32'(src_re), 32'(acc));
        chk("lb_we0", 32'(lb_we0), 32'(acc));
        chk("lb_re0", 32'(lb_re0), 32'(acc != 0 && r >= 1));
        chk("lb_re1", 32'(lb_re1), 32'(acc != 0 && r >= 2));
        chk("win_valid", 32'(win_valid), 32'(e_vld));
        chk("win_col", 32'(win_col), 32'(e_col));
        chk("win_row", 32'(win_row), 32'(e_row));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("lb_clr", 32'(lb_clr), 32'(e_clr));
        chk("cfg_err", 32'(cfg_err), 32'(e_err));

        if (src_re) begin n_re++; last_acc = cyc; end
        if (src_re && !dst_ready) n_re_nrdy++;
        if (lb_we0) n_we0++;
        if (lb_re0) n_re0++;
        if (lb_re1) n_re1++;
        if (lb_clr) n_clr++;
        if (cfg_err) n_err++;
        if (frame_done) begin n_done++; done_at = cyc; end
        if (win_valid) begin n_vld++; wins.push_back(int'(win_row) * 100 + int'(win_col)); end

        if (rst_n) begin
            e_vld = (acc != 0 && r >= 2 && c >= 2) ? 1 : 0;
            if (e_vld != 0) begin e_col = c - 1; e_row = r - 1; end
            e_clr = 0; e_err = 0; e_done = 0;
            case (mst)
                0: begin
                    if (abort) e_clr = 1;
                    else if (start) begin
                        if (int'(img_width) >= 3 && int'(img_width) <= 2048 && int'(img_height) >= 3) begin
                            mw = int'(img_width); mh = int'(img_height); mn = 0; mst = 1; e_clr = 1;
                        end else e_err = 1;
                    end
                end
                1: begin
                    if (abort) begin mst = 0; mn = 0; e_clr = 1; end
                    else if (acc != 0) begin
                        mn++;
                        if (mn == mw * mh) begin mst = 2; e_done = 1; end
                    end
                end
                default: begin mst = 0; if (abort) e_clr = 1; end
            endcase
            e_busy = (mst != 0) ? 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h);
        img_width = DW'(w); img_height = DW'(h); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: always flowing; mode 1: dst_ready toggles, src_nempty has random gaps
    task automatic run_frame(input int mode, input int stray_at);
        for (int i = 0; i < 3000 && mst != 0; i++) begin
            if (mode == 0) begin src_nempty = 1'b1; dst_ready = 1'b1; end
            else begin dst_ready = (i % 2) != 0; src_nempty = $urandom_range(0, 3) != 0; end
            if (i == stray_at) begin start = 1'b1; img_width = DW'(8); img_height = DW'(8); end
            tick();
            start = 1'b0;
        end
        src_nempty = 1'b0; dst_ready = 1'b0;
        tick();
        chk("frame_end_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_wins(input string name, input int s, input int exp[$]);
        chk({name, "_count"}, 32'(wins.size() - s), 32'(exp.size()));
        foreach (exp[i])
            if (s + i < wins.size()) chk(name, 32'(wins[s + i]), 32'(exp[i]));
    endtask

    int s_re, s_we0, s_re0, s_re1, s_vld, s_done, s_clr, s_err, s_w;
    task automatic snap();
        s_re = n_re; s_we0 = n_we0; s_re0 = n_re0; s_re1 = n_re1; s_vld = n_vld;
        s_done = n_done; s_clr = n_clr; s_err = n_err; s_w = wins.size();
    endtask

    initial begin
        int w5h4[$];
        int w4h4[$];
        int w4h3[$];
        w5h4 = '{101, 102, 103, 201, 202, 203};
        w4h4 = '{101, 102, 201, 202};
        w4h3 = '{101, 102};

        model_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; src_nempty = 1'b1; dst_ready = 1'b1;
        img_width = '0; img_height = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Plain W=5 H=4 frame
        snap();
        do_start(5, 4);
        run_frame(0, -1);
        chk("A_src_re", 32'(n_re - s_re), 32'd20);
        chk("A_lb_we0", 32'(n_we0 - s_we0), 32'd20);
        chk("A_lb_re0", 32'(n_re0 - s_re0), 32'd15);
        chk("A_lb_re1", 32'(n_re1 - s_re1), 32'd10);
        chk("A_windows", 32'(n_vld - s_vld), 32'd6);
        chk("A_done_cnt", 32'(n_done - s_done), 32'd1);
        chk("A_done_lat", 32'(done_at - last_acc), 32'd1);
        chk("A_clr_cnt", 32'(n_clr - s_clr), 32'd1);
        chk_wins("A_win", s_w, w5h4);

        // Same frame under back-pressure
        snap();
        n_re_nrdy = 0;
        do_start(5, 4);
        run_frame(1, -1);
        chk("B_src_re", 32'(n_re - s_re), 32'd20);
        chk("B_re_nrdy", 32'(n_re_nrdy), 32'd0);
        chk("B_done_cnt", 32'(n_done - s_done), 32'd1);
        chk_wins("B_win", s_w, w5h4);

        // Illegal geometry
        snap();
        src_nempty = 1'b1; dst_ready = 1'b1;
        do_start(2, 10); tick();
        do_start(2049, 10); tick();
        do_start(8, 2); tick();
        tick();
        chk("C_cfg_err", 32'(n_err - s_err), 32'd3);
        chk("C_src_re", 32'(n_re - s_re), 32'd0);
        chk("C_busy", 32'(busy), 32'd0);

        // Abort after 30 accepts, colliding with a valid accept
        snap();
        do_start(8, 8);
        for (int i = 0; i < 200 && mn < 30; i++) begin
            src_nempty = 1'b1; dst_ready = 1'b1; tick();
        end
        chk("D_pre_abort", 32'(n_re - s_re), 32'd30);
        s_clr = n_clr;
        abort = 1'b1; tick(); abort = 1'b0;
        src_nempty = 1'b0; dst_ready = 1'b0;
        tick(); tick();
        chk("D_src_re", 32'(n_re - s_re), 32'd30);
        chk("D_clr_cnt", 32'(n_clr - s_clr), 32'd1);
        chk("D_no_done", 32'(n_done - s_done), 32'd0);
        chk("D_busy", 32'(busy), 32'd0);
        snap();
        do_start(4, 4);
        run_frame(0, -1);
        chk_wins("D_win", s_w, w4h4);

        // start during RUN with other geometry is ignored
        snap();
        do_start(5, 4);
        run_frame(0, 5);
        chk("E_src_re", 32'(n_re - s_re), 32'd20);
        chk_wins("E_win", s_w, w5h4);

        // abort and start together in IDLE
        snap();
        img_width = DW'(6); img_height = DW'(6); start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick(); tick();
        chk("F_clr_cnt", 32'(n_clr - s_clr), 32'd1);
        chk("F_busy", 32'(busy), 32'd0);
        chk("F_cfg_err", 32'(n_err - s_err), 32'd0);

        // Asynchronous reset mid-frame, then a fresh frame
        do_start(6, 5);
        src_nempty = 1'b1; dst_ready = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        snap();
        do_start(4, 3);
        run_frame(0, -1);
        chk_wins("G_win", s_w, w4h3);

        // Random geometries under random back-pressure
        for (int f = 0; f < 6; f++) begin
            int w, h;
            w = $urandom_range(3, 10);
            h = $urandom_range(3, 6);
            snap();
            do_start(w, h);
            run_frame(int'($urandom_range(0, 1)), -1);
            chk("R_windows", 32'(n_vld - s_vld), 32'((w - 2) * (h - 2)));
            chk("R_src_re", 32'(n_re - s_re), 32'(w * h));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
Frame sequencer for the Sobel two-line buffer. It latches the image geometry at frame start and tracks the column and row of every pixel accepted from the upstream FIFO. It drives the line-buffer write and read enables explicitly, so priming no longer depends on almost-full flags. It tags each accepted pixel that completes an interior 3x3 window with a valid strobe and the window-centre coordinates.

Parameters:
LB_DEPTH, 2048, depth of each line-buffer FIFO; maximum legal image width.
DIM_W, 12, width of the geometry inputs and coordinate counters.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse that begins a frame; ignored unless in IDLE.
abort  input  1  one-cycle pulse that terminates the current frame.
img_width  input  DIM_W  pixels per line; sampled on start.
img_height  input  DIM_W  lines per frame; sampled on start.
src_nempty  input  1  upstream FIFO not empty.
src_re  output  1  upstream FIFO read enable (combinational).
dst_ready  input  1  downstream can accept a window.
lb_we0  output  1  write enable for line FIFO 0 (combinational).
lb_re0  output  1  read enable for line FIFO 0, which is also the write enable for line FIFO 1 (combinational).
lb_re1  output  1  read enable for line FIFO 1 (combinational).
lb_clr  output  1  registered one-cycle pulse that synchronously clears both line FIFOs.
win_valid  output  1  registered; a complete 3x3 window has been presented.
win_col  output  DIM_W  registered; window-centre column.
win_row  output  DIM_W  registered; window-centre row.
busy  output  1  registered; high while in RUN or DONE.
frame_done  output  1  registered one-cycle pulse at the end of a frame.
cfg_err  output  1  registered one-cycle pulse when start carries illegal geometry.

Behaviour:
- Reset: every registered output is 0, state is IDLE, and col and row are 0. Combinational outputs are 0 in IDLE.
- States and transitions:
  - IDLE: on start with legal geometry, latch W = img_width and H = img_height, clear col and row, pulse lb_clr, and go to RUN.
  - Geometry is legal only if 3 <= W <= LB_DEPTH and H >= 3. Otherwise pulse cfg_err and stay in IDLE.
  - RUN: accept = src_nempty & dst_ready. No pixel is accepted in any other state.
  - DONE: lasts exactly one cycle, then go to IDLE. frame_done is high during the cycle after DONE is entered.
- Combinational enables:
  - src_re = accept; lb_we0 = accept.
  - lb_re0 = accept & (row >= 1); lb_re1 = accept & (row >= 2).
- Counters (advance on accept only):
  - col increments; when col == W-1 it wraps to 0 and row increments.
  - Accepting the pixel at col == W-1, row == H-1 moves the state to DONE.
- Window tagging, one-cycle latency from accept:
  - win_valid <= accept & (row >= 2) & (col >= 2).
  - win_col <= col-1; win_row <= row-1.
  - When win_valid is 0, win_col and win_row hold their last values.
- Window count: exactly (W-2)*(H-2) win_valid pulses per frame. Border pixels produce none. No padding or flush phase exists.
- Back-pressure: while src_nempty or dst_ready is low, counters and all enables hold or are deasserted. A stall never loses or duplicates a pixel.
- start while busy is ignored; the latched geometry is unchanged.
- abort in RUN or DONE:
  - Next state is IDLE; counters clear; lb_clr pulses; no frame_done.
  - win_valid is forced to 0 in the cycle after abort.
  - abort has priority over a simultaneous accept; the pixel is not read (src_re = 0 that cycle).
- abort and start together in IDLE: abort wins; no frame starts and lb_clr pulses once.
- Asynchronous reset mid-frame returns the block to its reset state immediately. Line-buffer contents are don't-care; they are cleared on the next start via lb_clr.
- Arithmetic: counters are DIM_W bits and are never compared beyond W-1 or H-1, so they cannot overflow.

Test Plan:
- W=5, H=4, src_nempty=1, dst_ready=1 continuously -> 20 src_re cycles, 6 win_valid pulses with (row,col) centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3), frame_done 1 cycle after the 20th accept, then busy=0.
- Same frame with dst_ready toggling every other cycle and random src_nempty gaps -> identical window sequence; src_re never asserted when dst_ready=0.
- Check lb_re0 and lb_re1 counts over the W=5, H=4 frame -> lb_we0 asserted 20 times, lb_re0 15 times, lb_re1 10 times.
- start with W=2,H=10; then W=2049,H=10; then W=8,H=2 -> one cfg_err pulse each, busy stays 0, and src_re is never asserted.
- W=8, H=8: abort after 30 accepts, with abort in the same cycle as a valid accept -> that pixel is not read, lb_clr pulses once, no frame_done; a following start with W=4, H=4 produces 4 windows correctly.
- Drive start during RUN with different geometry -> ignored; the frame completes with its original W×H window count.
